// File: rtl/ssd1306_i2c_target.sv
// SSD1306-compatible I2C write target: ACKs ADDR7, splits control/command/data
// bytes and turns GDDRAM data into page-mode pixel writes for a frame-buffer model.
module ssd1306_i2c_target #(
  parameter logic [6:0]  ADDR7       = 7'h3C,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dcn,
  output logic       pix_we,
  output logic [2:0] pix_page,
  output logic [6:0] pix_col,
  output logic [7:0] pix_data,
  output logic       disp_on,
  output logic       busy
);

  localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  logic [NSYNC-1:0] scl_sync_r;
  logic [NSYNC-1:0] sda_sync_r;
  logic             scl_d_r;
  logic             sda_d_r;
  logic             scl_s;
  logic             sda_s;
  logic             scl_rise_s;
  logic             scl_fall_s;
  logic             start_s;
  logic             stop_s;

  state_t           state_r;
  state_t           state_nxt;
  logic [2:0]       bit_cnt_r;
  logic [2:0]       bit_cnt_nxt;
  logic [6:0]       shift_r;
  logic [6:0]       shift_nxt;
  logic [7:0]       rx_byte_s;
  logic             ack_nxt;
  logic             ctrl_load_s;
  logic             data_done_s;

  logic             co_r;
  logic             dc_r;
  logic [2:0]       page_r;
  logic [6:0]       col_r;
  logic [1:0]       arg_pending_r;

  // Number of argument bytes that follow a multi-byte SSD1306 command.
  function automatic logic [1:0] cmd_arg_count(input logic [7:0] cmd);
    case (cmd)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB: cmd_arg_count = 2'd1;
      8'h21, 8'h22:               cmd_arg_count = 2'd2;
      default:                    cmd_arg_count = 2'd0;
    endcase
  endfunction

  assign scl_s      = scl_sync_r[NSYNC-1];
  assign sda_s      = sda_sync_r[NSYNC-1];
  assign scl_rise_s = scl_s & ~scl_d_r;
  assign scl_fall_s = ~scl_s & scl_d_r;
  assign start_s    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop_s     = scl_s & scl_d_r & ~sda_d_r & sda_s;
  assign rx_byte_s  = {shift_r, sda_s};

  // Pad synchronizers plus edge-detect stage; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {NSYNC{1'b1}};
      sda_sync_r <= {NSYNC{1'b1}};
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[NSYNC-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[NSYNC-2:0], sda_in};
      scl_d_r    <= scl_s;
      sda_d_r    <= sda_s;
    end
  end

  // Bus FSM next state: bit shifting, address match and ACK handshakes.
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    ack_nxt     = sda_oe;
    ctrl_load_s = 1'b0;
    data_done_s = 1'b0;
    if (start_s || stop_s) begin
      state_nxt   = start_s ? ST_ADDR : ST_IDLE;
      bit_cnt_nxt = 3'd0;
      ack_nxt     = 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_CTRL, ST_DATA: begin
          if (scl_rise_s) begin
            shift_nxt   = rx_byte_s[6:0];
            bit_cnt_nxt = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              case (state_r)
                ST_ADDR: begin
                  state_nxt = ((rx_byte_s[7:1] == ADDR7) && !rx_byte_s[0]) ? ST_ADDR_ACK : ST_IGNORE;
                end
                ST_CTRL: begin
                  state_nxt   = ST_CTRL_ACK;
                  ctrl_load_s = 1'b1;
                end
                default: begin
                  state_nxt   = ST_DATA_ACK;
                  data_done_s = 1'b1;
                end
              endcase
            end else begin
              state_nxt = state_r;
            end
          end else begin
            shift_nxt = shift_r;
          end
        end
        // First SCL fall pulls SDA low, the next one (end of 9th clock) lets go.
        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          if (scl_fall_s && !sda_oe) begin
            ack_nxt = 1'b1;
          end else if (scl_fall_s) begin
            ack_nxt = 1'b0;
            case (state_r)
              ST_ADDR_ACK: state_nxt = ST_CTRL;
              ST_CTRL_ACK: state_nxt = ST_DATA;
              default:     state_nxt = co_r ? ST_CTRL : ST_DATA;
            endcase
          end else begin
            ack_nxt = sda_oe;
          end
        end
        default: begin
          state_nxt = state_r;
        end
      endcase
    end
  end

  // Bus FSM state, shift register, open-drain ACK drive and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      sda_oe    <= ack_nxt;
      if (start_s) begin
        busy <= 1'b1;
      end else if (stop_s) begin
        busy <= 1'b0;
      end
    end
  end

  // Control-byte latch, command decode and page-mode pixel pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_r          <= 1'b0;
      dc_r          <= 1'b0;
      byte_valid    <= 1'b0;
      byte_data     <= 8'd0;
      byte_dcn      <= 1'b0;
      pix_we        <= 1'b0;
      pix_page      <= 3'd0;
      pix_col       <= 7'd0;
      pix_data      <= 8'd0;
      page_r        <= 3'd0;
      col_r         <= 7'd0;
      arg_pending_r <= 2'd0;
      disp_on       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      pix_we     <= 1'b0;
      if (ctrl_load_s) begin
        co_r <= rx_byte_s[7];
        dc_r <= rx_byte_s[6];
      end
      if (data_done_s) begin
        byte_valid <= 1'b1;
        byte_data  <= rx_byte_s;
        byte_dcn   <= dc_r;
        if (dc_r) begin
          // Column wraps 127 -> 0 within the same page.
          pix_we   <= 1'b1;
          pix_page <= page_r;
          pix_col  <= col_r;
          pix_data <= rx_byte_s;
          col_r    <= col_r + 7'd1;
        end else if (arg_pending_r != 2'd0) begin
          arg_pending_r <= arg_pending_r - 2'd1;
        end else if (rx_byte_s[7:4] == 4'h0) begin
          col_r[3:0] <= rx_byte_s[3:0];
        end else if (rx_byte_s[7:3] == 5'b00010) begin
          col_r[6:4] <= rx_byte_s[2:0];
        end else if (rx_byte_s[7:3] == 5'b10110) begin
          page_r <= rx_byte_s[2:0];
        end else if (rx_byte_s == 8'hAF) begin
          disp_on <= 1'b1;
        end else if (rx_byte_s == 8'hAE) begin
          disp_on <= 1'b0;
        end else begin
          arg_pending_r <= cmd_arg_count(rx_byte_s);
        end
      end
    end
  end

endmodule
